// File: rtl/otter_mem_arbiter.sv
// Shares one single-port, variable-latency memory between OTTER instruction fetch and load/store.
// Data wins over fetch, one transaction in flight, bounded by an optional timeout.
module otter_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        MA_CLK,
    input  logic        MA_RESET,
    input  logic        MA_IF_REQ,
    input  logic [31:0] MA_IF_ADDR,
    output logic [31:0] MA_IF_RDATA,
    output logic        MA_IF_DONE,
    input  logic        MA_D_REQ,
    input  logic        MA_D_WE,
    input  logic [31:0] MA_D_ADDR,
    input  logic [1:0]  MA_D_SIZE,
    input  logic [31:0] MA_D_WDATA,
    output logic [31:0] MA_D_RDATA,
    output logic        MA_D_DONE,
    output logic        MA_D_MISALIGN,
    output logic        MA_MEM_REQ,
    output logic        MA_MEM_WE,
    output logic [31:0] MA_MEM_ADDR,
    output logic [3:0]  MA_MEM_BE,
    output logic [31:0] MA_MEM_WDATA,
    input  logic        MA_MEM_ACK,
    input  logic [31:0] MA_MEM_RDATA,
    output logic        MA_BUSY,
    output logic        MA_TIMEOUT
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MEM_IF = 2'd1;
    localparam logic [1:0] ST_MEM_D  = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             lat_we;
    logic             d_misal;
    logic [3:0]       d_be;
    logic [31:0]      d_wdata;
    logic             to_hit;
    logic             unused_if_addr;

    // Fetches are always word-aligned by construction; the low bits are dropped.
    assign unused_if_addr = ^MA_IF_ADDR[1:0];

    assign d_misal = ((MA_D_SIZE == 2'b01) && MA_D_ADDR[0]) ||
                     (MA_D_SIZE[1] && (MA_D_ADDR[1:0] != 2'b00));

    always_comb begin
        d_be    = 4'b1111;
        d_wdata = MA_D_WDATA;
        case (MA_D_SIZE)
            2'b00: begin
                d_be    = 4'b0001 << MA_D_ADDR[1:0];
                d_wdata = {4{MA_D_WDATA[7:0]}};
            end
            2'b01: begin
                d_be    = 4'b0011 << {MA_D_ADDR[1], 1'b0};
                d_wdata = {2{MA_D_WDATA[15:0]}};
            end
            default: ;
        endcase
    end

    // The counter sits at TIMEOUT_CYCLES-1 on the last allowed wait cycle.
    assign to_hit  = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);
    assign MA_BUSY = (state != ST_IDLE);

    always_ff @(posedge MA_CLK or posedge MA_RESET) begin
        if (MA_RESET) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            lat_we        <= 1'b0;
            MA_IF_RDATA   <= '0;
            MA_IF_DONE    <= 1'b0;
            MA_D_RDATA    <= '0;
            MA_D_DONE     <= 1'b0;
            MA_D_MISALIGN <= 1'b0;
            MA_MEM_REQ    <= 1'b0;
            MA_MEM_WE     <= 1'b0;
            MA_MEM_ADDR   <= '0;
            MA_MEM_BE     <= '0;
            MA_MEM_WDATA  <= '0;
            MA_TIMEOUT    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (MA_D_REQ) begin
                        lat_we <= MA_D_WE;
                        if (d_misal) begin
                            state         <= ST_RESP;
                            MA_D_DONE     <= 1'b1;
                            MA_D_MISALIGN <= 1'b1;
                        end else begin
                            state        <= ST_MEM_D;
                            MA_MEM_REQ   <= 1'b1;
                            MA_MEM_WE    <= MA_D_WE;
                            MA_MEM_ADDR  <= {MA_D_ADDR[31:2], 2'b00};
                            MA_MEM_BE    <= d_be;
                            MA_MEM_WDATA <= d_wdata;
                        end
                    end else if (MA_IF_REQ) begin
                        state        <= ST_MEM_IF;
                        MA_MEM_REQ   <= 1'b1;
                        MA_MEM_WE    <= 1'b0;
                        MA_MEM_ADDR  <= {MA_IF_ADDR[31:2], 2'b00};
                        MA_MEM_BE    <= 4'b1111;
                        MA_MEM_WDATA <= '0;
                    end
                end
                ST_MEM_IF, ST_MEM_D: begin
                    if (MA_MEM_ACK || to_hit) begin
                        state      <= ST_RESP;
                        cnt        <= '0;
                        MA_MEM_REQ <= 1'b0;
                        MA_MEM_WE  <= 1'b0;
                        if (!MA_MEM_ACK)
                            MA_TIMEOUT <= 1'b1;
                        if (state == ST_MEM_IF) begin
                            MA_IF_DONE  <= 1'b1;
                            MA_IF_RDATA <= MA_MEM_ACK ? MA_MEM_RDATA : 32'h0;
                        end else begin
                            MA_D_DONE <= 1'b1;
                            if (!MA_MEM_ACK)
                                MA_D_RDATA <= 32'h0;
                            else if (!lat_we)
                                MA_D_RDATA <= MA_MEM_RDATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    MA_IF_DONE    <= 1'b0;
                    MA_D_DONE     <= 1'b0;
                    MA_D_MISALIGN <= 1'b0;
                end
            endcase
        end
    end

endmodule
